// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame format constants and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int   DEFAULT_CLK_DIV = 5208;
    localparam int   DATA_BITS       = 8;
    localparam logic START_LEVEL     = 1'b0;
    localparam logic STOP_LEVEL      = 1'b1;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte request handshake between the loopback controller and uart_tx
interface uart_tx_if;
    logic [7:0] TX_data;
    logic       TX_en;
    logic       TX_status;

    modport master (output TX_data, output TX_en, input TX_status);
    modport slave  (input TX_data, input TX_en, output TX_status);
endinterface

// File: rtl/baud_tick.sv
// rtl/baud_tick.sv - free-running 0..DIV-1 counter with clear; tick is high on the last count
module baud_tick #(
    parameter int DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    output logic tick
);
    localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    uart_tx_if.slave    tx_if,
    output logic        UART_TX
);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       par_q, par_d;
    logic       line_q, line_d;
    logic       status_q, status_d;
    logic       baud_clr;
    logic       bit_end;

    baud_tick #(.DIV(CLK_DIV)) u_baud (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (baud_clr),
        .tick      (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        baud_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_if.TX_en) begin
                    state_d   = ST_START;
                    shift_d   = tx_if.TX_data;
                    bit_cnt_d = '0;
                    par_d     = parity_bit(tx_if.TX_data, PARITY_ODD);
                    baud_clr  = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // bit counter is reused to count stop bits
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // outputs are registered from the next state so they switch on the same edge as the FSM
        case (state_d)
            ST_START:  line_d = START_LEVEL;
            ST_DATA:   line_d = shift_d[0];
            ST_PARITY: line_d = par_d;
            default:   line_d = STOP_LEVEL;
        endcase
        status_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            line_q    <= 1'b1;
            status_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            line_q    <= line_d;
            status_q  <= status_d;
        end
    end

    assign UART_TX         = line_q;
    assign tx_if.TX_status = status_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx: four format variants driven by one shared request
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       line0, line1, line2, line3;
    int         total = 0;
    int         bad   = 0;

    logic [3:0] ln_s [0:159];
    logic [3:0] st_s [0:159];

    always #5 clk = ~clk;

    // d0: 8N1, d1: 8E1, d2: 8O1, d3: 8N2, all with 4 clocks per bit
    uart_tx_if u0 ();
    uart_tx_if u1 ();
    uart_tx_if u2 ();
    uart_tx_if u3 ();
    assign u0.TX_data = tx_data;  assign u0.TX_en = tx_en;
    assign u1.TX_data = tx_data;  assign u1.TX_en = tx_en;
    assign u2.TX_data = tx_data;  assign u2.TX_en = tx_en;
    assign u3.TX_data = tx_data;  assign u3.TX_en = tx_en;

    uart_tx #(.CLK_DIV(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_if(u0), .UART_TX(line0));
    uart_tx #(.CLK_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_if(u1), .UART_TX(line1));
    uart_tx #(.CLK_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_if(u2), .UART_TX(line2));
    uart_tx #(.CLK_DIV(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut3 (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_if(u3), .UART_TX(line3));

    wire [3:0] lines_w = {line3, line2, line1, line0};
    wire [3:0] stats_w = {u3.TX_status, u2.TX_status, u1.TX_status, u0.TX_status};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // records one sample per cycle at the falling edge; optional mid-capture data change and reset pulse
    task automatic capture(input int n, input int chg_at, input logic [7:0] chg_val, input int rst_at);
        for (int i = 0; i < n; i++) begin
            ln_s[i] = lines_w;
            st_s[i] = stats_w;
            if (i == chg_at) tx_data = chg_val;
            if (i == rst_at) rst_n = 1'b0;
            if (i == rst_at + 1) rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic pulse_request(input logic [7:0] d);
        tx_data = d;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en   = 1'b0;
    endtask

    // bits[0] is the start bit; each bit must hold for 4 samples, then one idle sample follows
    task automatic check_frame(input string tag, input int d, input int off,
                               input logic [11:0] bits, input int nb);
        logic [3:0] g;
        int         busy_err;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < 4; c++) g[c] = ln_s[off + b*4 + c][d];
            check_eq($sformatf("%s_bit%0d", tag, b), 32'(g), 32'({4{bits[b]}}));
        end
        busy_err = 0;
        for (int i = 0; i < nb*4; i++) if (st_s[off + i][d] !== 1'b0) busy_err++;
        check_eq($sformatf("%s_busy", tag), 32'(busy_err), 32'd0);
        check_eq($sformatf("%s_idle", tag),
                 32'({st_s[off + nb*4][d], ln_s[off + nb*4][d]}), 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nonidle;
        int waited;
        rst_n   = 1'b0;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("reset_line", 32'(lines_w), 32'hF);
        check_eq("reset_status", 32'(stats_w), 32'hF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: 0x55, one-cycle pulse
        pulse_request(8'h55);
        capture(48, -1, 8'h00, -10);
        check_frame("t1_d0", 0, 0, 12'({1'b1, 8'h55, 1'b0}), 10);
        check_frame("t1_d1", 1, 0, 12'({1'b1, 1'b0, 8'h55, 1'b0}), 11);
        check_frame("t1_d2", 2, 0, 12'({1'b1, 1'b1, 8'h55, 1'b0}), 11);
        check_frame("t1_d3", 3, 0, 12'({2'b11, 8'h55, 1'b0}), 11);

        // 2: 0x07 has three ones: even parity 1, odd parity 0
        pulse_request(8'h07);
        capture(48, -1, 8'h00, -10);
        check_frame("t2_d0", 0, 0, 12'({1'b1, 8'h07, 1'b0}), 10);
        check_frame("t2_even", 1, 0, 12'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
        check_frame("t2_odd", 2, 0, 12'({1'b1, 1'b0, 8'h07, 1'b0}), 11);

        // 3: 0xA3 sent as 1,1,0,0,0,1,0,1; two stop bits hold the line high 8 cycles
        pulse_request(8'hA3);
        capture(48, -1, 8'h00, -10);
        check_frame("t3_stop2", 3, 0, 12'({2'b11, 8'hA3, 1'b0}), 11);
        check_frame("t3_d1", 1, 0, 12'({1'b1, 1'b0, 8'hA3, 1'b0}), 11);

        // 4: hold request until busy, change data mid-frame
        tx_data = 8'h96;
        tx_en   = 1'b1;
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (stats_w[0] !== 1'b0 && waited < 10);
        check_eq("t4_ack", 32'(stats_w[0]), 32'd0);
        tx_en = 1'b0;
        capture(100, 10, 8'hFF, -10);
        check_frame("t4_d0", 0, 0, 12'({1'b1, 8'h96, 1'b0}), 10);
        nonidle = 0;
        for (int i = 41; i < 100; i++) if (ln_s[i][0] !== 1'b1 || st_s[i][0] !== 1'b1) nonidle++;
        check_eq("t4_no_second_frame", 32'(nonidle), 32'd0);

        // 5: request held permanently -> back-to-back frames with one idle cycle
        tx_data = 8'h3C;
        tx_en   = 1'b1;
        @(negedge clk);
        capture(130, -1, 8'h00, -10);
        tx_en = 1'b0;
        check_frame("t5_f0", 0, 0, 12'({1'b1, 8'h3C, 1'b0}), 10);
        check_frame("t5_f1", 0, 41, 12'({1'b1, 8'h3C, 1'b0}), 10);
        check_frame("t5_f2", 0, 82, 12'({1'b1, 8'h3C, 1'b0}), 10);
        check_frame("t5_d3_f1", 3, 45, 12'({2'b11, 8'h3C, 1'b0}), 11);
        repeat (60) @(negedge clk);

        // 6: reset during data bit 3 (samples 16..19), frame abandoned
        pulse_request(8'h81);
        capture(48, -1, 8'h00, 17);
        check_eq("t6_rst_line", 32'(ln_s[18]), 32'hF);
        check_eq("t6_rst_status", 32'(st_s[18]), 32'hF);
        nonidle = 0;
        for (int i = 18; i < 48; i++) if (ln_s[i] !== 4'hF || st_s[i] !== 4'hF) nonidle++;
        check_eq("t6_not_resumed", 32'(nonidle), 32'd0);
        pulse_request(8'h81);
        capture(48, -1, 8'h00, -10);
        check_frame("t6_d0", 0, 0, 12'({1'b1, 8'h81, 1'b0}), 10);
        check_frame("t6_d1", 1, 0, 12'({1'b1, 1'b0, 8'h81, 1'b0}), 11);
        check_frame("t6_d2", 2, 0, 12'({1'b1, 1'b1, 8'h81, 1'b0}), 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
